// File: rtl/des_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_pkg                                                              |
// | Widths, E/P tables and permutation helpers for the DES round.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package des_pkg;

    localparam int DES_HALF_W = 32;
    localparam int DES_KEY_W  = 48;

    // Table entries are DES bit numbers: 1 is the MSB of the source vector.
    localparam int c_e_tab [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int c_p_tab [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    function automatic logic [DES_KEY_W-1:0] des_expand(input logic [DES_HALF_W-1:0] r);
        logic [DES_KEY_W-1:0] e;
        e = '0;
        for (int i = 0; i < DES_KEY_W; i++) begin
            e[DES_KEY_W-1-i] = r[DES_HALF_W - c_e_tab[i]];
        end
        return e;
    endfunction

    function automatic logic [DES_HALF_W-1:0] des_permute_p(input logic [DES_HALF_W-1:0] s);
        logic [DES_HALF_W-1:0] p;
        p = '0;
        for (int i = 0; i < DES_HALF_W; i++) begin
            p[DES_HALF_W-1-i] = s[DES_HALF_W - c_p_tab[i]];
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_sbox_layer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_sbox / des_sbox_layer                                            |
// | Combinational DES S-box layer: 48-bit input to 32-bit output.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module des_sbox #(
    // 64 nibbles, entry (row*16 + col) starting at the MSB end
    parameter logic [255:0] TABLE = '0
) (
    input  logic [5:0] din,
    output logic [3:0] dout
);

    logic [5:0] w_idx;
    logic [7:0] w_base;

    assign w_idx  = {din[5], din[0], din[4:1]};
    assign w_base = 8'd255 - {w_idx, 2'b00};
    assign dout   = TABLE[w_base -: 4];

endmodule

module des_sbox_layer
    import des_pkg::*;
(
    input  logic [DES_KEY_W-1:0]  x,
    output logic [DES_HALF_W-1:0] y
);

    localparam logic [255:0] c_sbox [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    for (genvar j = 0; j < 8; j++) begin : g_sbox
        des_sbox #(
            .TABLE (c_sbox[j])
        ) u_sbox (
            .din  (x[DES_KEY_W-1-6*j -: 6]),
            .dout (y[DES_HALF_W-1-4*j -: 4])
        );
    end

endmodule
`default_nettype wire

// File: rtl/des_f_round_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | des_f_round_pipe                                                     |
// | Two-stage pipelined DES Feistel round with valid/ready handshake.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module des_f_round_pipe
    import des_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DES_HALF_W-1:0] in_l,
    input  logic [DES_HALF_W-1:0] in_r,
    input  logic [DES_KEY_W-1:0]  in_key,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DES_HALF_W-1:0] out_l,
    output logic [DES_HALF_W-1:0] out_r
);

    logic                  r_s1_v;
    logic                  r_s2_v;
    logic                  r_s1_last;
    logic [DES_KEY_W-1:0]  r_s1_x;
    logic [DES_HALF_W-1:0] r_s1_l;
    logic [DES_HALF_W-1:0] r_s1_r;
    logic [DES_HALF_W-1:0] r_out_l;
    logic [DES_HALF_W-1:0] r_out_r;

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    logic                  w_accept;
    logic [DES_HALF_W-1:0] w_sbox_out;
    logic [DES_HALF_W-1:0] w_f;
    logic [DES_HALF_W-1:0] w_l_xor_f;

    assign w_s2_adv  = !r_s2_v || out_ready;
    assign w_s1_adv  = r_s1_v && w_s2_adv;
    assign in_ready  = !r_s1_v || w_s2_adv;
    assign w_accept  = in_valid && in_ready;

    des_sbox_layer u_sbox_layer (
        .x (r_s1_x),
        .y (w_sbox_out)
    );

    assign w_f       = des_permute_p(w_sbox_out);
    assign w_l_xor_f = r_s1_l ^ w_f;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v    <= 1'b0;
            r_s2_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_x    <= '0;
            r_s1_l    <= '0;
            r_s1_r    <= '0;
            r_out_l   <= '0;
            r_out_r   <= '0;
        end else begin
            // A new accept may overwrite stage 1 on the same edge it drains.
            if (w_accept) begin
                r_s1_v    <= 1'b1;
                r_s1_x    <= des_expand(in_r) ^ in_key;
                r_s1_l    <= in_l;
                r_s1_r    <= in_r;
                r_s1_last <= in_last;
            end else if (w_s1_adv) begin
                r_s1_v    <= 1'b0;
            end

            if (w_s2_adv) begin
                r_s2_v <= r_s1_v;
            end

            if (w_s1_adv) begin
                if (r_s1_last) begin
                    r_out_l <= w_l_xor_f;
                    r_out_r <= r_s1_r;
                end else begin
                    r_out_l <= r_s1_r;
                    r_out_r <= w_l_xor_f;
                end
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_l     = r_out_l;
    assign out_r     = r_out_r;

endmodule
`default_nettype wire
